viterbi_decoder: RTL and testbench
==================================

Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional code (generators 7 and 5 octal).
- Sits after the demodulator. It consumes one 2-bit code symbol per in_valid strobe and recovers the original M-sequence bit stream.
- Uses a 4-state add-compare-select with min-normalised path metrics and register-exchange survivor memory.
- Output is available TB_DEPTH symbols after input.

Parameters:
- TB_DEPTH, 16, survivor length in symbols, which is also the decode latency in accepted symbols; legal range 4..32.
- PM_W, 5, path-metric width in bits; minimum 4.
- PM_INIT, 4, initial metric of states 1..3 after reset, so decoding starts from state 0.

Ports:
- clk  input  1  single system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  conv_in holds a new symbol this cycle
- conv_in  input  2  received symbol; [1]=g7 branch bit, [0]=g5 branch bit
- bit_out  output  1  decoded bit, qualified by out_valid
- out_valid  output  1  one-cycle strobe per decoded bit
- best_metric  output  PM_W  normalised metric of the winning state; a quality indicator, 0 on an error-free stream

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Code definition (fixed):
  - State s = {m[n-1], m[n-2]}.
  - For input u from state {a,b}: expected symbol is {u^a^b, u^b}.
  - Next state is {u,a}.
- Reset values:
  - PM[0]=0, PM[1..3]=PM_INIT.
  - All survivors 0; symbol counter 0.
  - bit_out=0, out_valid=0, best_metric=0.
  - The async assert clears mid-stream state immediately; the first symbol after deassert is treated as symbol 0.
- Per accepted symbol (in_valid=1), all in one cycle, registered:
  - Branch metric BM = Hamming distance(conv_in, expected), range 0..2.
  - For each next state ns={u,a}, the predecessors are p0={a,0} and p1={a,1}.
  - Candidate cN = PM[pN] + BM(pN→ns).
  - Select p0 if c0 <= c1 (tie goes to the lower-index predecessor).
  - Survivor update: surv[ns] <= {surv[sel][TB_DEPTH-2:0], u}.
  - Normalisation: new PM[ns] = cand_sel - min over the four cand_sel values.
  - Metric bound: with PM_INIT=4 all metrics stay <= 6, so PM_W=4 suffices and there is no wrap or saturation path.
- Best state:
  - The lowest index among states with minimum new PM; ties go to the lowest index.
  - best_metric is the un-normalised minimum minus the previous minimum, clamped to PM_W bits.
- Output timing:
  - The counter saturates at TB_DEPTH.
  - When in_valid=1 and the counter (before increment) >= TB_DEPTH-1, the next cycle has out_valid=1 and bit_out = surv_new[best][TB_DEPTH-1].
  - Latency: the bit encoded with symbol k is output one clock after symbol k+TB_DEPTH-1 is accepted.
- in_valid=0: all state holds and out_valid=0. Gaps of any length are legal and do not affect results.
- Back-to-back in_valid every cycle is supported at full throughput.
- There is no flush input. The final TB_DEPTH-1 bits are emitted only if the upstream sends tail symbols (2 zero input bits terminate the trellis).

Decomposition:
- Package viterbi_pkg holds:
  - constants NUM_STATES=4, K=3, G0=3'b111, G1=3'b101;
  - a function expected_sym(state, u) returning 2 bits;
  - a function hamming2.
- The encoder model in the testbench reuses viterbi_pkg.
- One natural sub-module, viterbi_acs: one next-state add-compare-select unit, instantiated 4 times. It takes two PMs, two BMs and two survivors, and returns the selected candidate and the new survivor.

Test Plan:
- Error-free stream:
  - Stimulus: M-sequence bits 1,0,1,1,0,0,1,... encoded from state 0 and fed back-to-back, TB_DEPTH=16.
  - Required: first out_valid one clock after symbol 15; bit_out sequence equals the input bits; best_metric=0 throughout.
- Single error:
  - Stimulus: same stream with conv_in[1] flipped at symbol 20.
  - Required: decoded stream identical to the input; best_metric=1 within a few symbols, then back to 0 once the trellis reconverges.
- All-zero input:
  - Stimulus: 40 symbols of 2'b00.
  - Required: 25 out_valid pulses, all bit_out=0; PM[0] stays 0.
- Gapped in_valid:
  - Stimulus: the error-free stream with in_valid asserted every 3rd cycle.
  - Required: same bits as the back-to-back case; out_valid only one clock after accepting strobes.
- Reset mid-stream:
  - Stimulus: assert reset asynchronously (not clock-aligned) at symbol 30.
  - Required: out_valid=0 and bit_out=0 immediately; after release, a new stream decodes with fresh 16-symbol latency.
- Two spaced errors:
  - Stimulus: single-bit errors at symbols 10 and 25 (more than 5 symbols apart).
  - Required: all decoded bits correct.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2, K=3 (7,5 octal) hard-decision Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned NUM_STATES = 4;
  localparam int unsigned K          = 3;
  localparam logic [K-1:0] G0        = 3'b111;
  localparam logic [K-1:0] G1        = 3'b101;

  // Encoder register is {u, a, b} for input u leaving state {a, b}.
  function automatic logic [1:0] expected_sym(input logic [1:0] state, input logic u);
    logic [K-1:0] r;
    r = {u, state};
    return {^(r & G0), ^(r & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return 2'(x[1]) + 2'(x[0]);
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one next state; tie selects the lower-index predecessor.
module viterbi_acs #(
  parameter int unsigned PM_W     = 5,
  parameter int unsigned TB_DEPTH = 16
) (
  input  logic [PM_W-1:0]     pm0_i,
  input  logic [PM_W-1:0]     pm1_i,
  input  logic [1:0]          bm0_i,
  input  logic [1:0]          bm1_i,
  input  logic [TB_DEPTH-1:0] surv0_i,
  input  logic [TB_DEPTH-1:0] surv1_i,
  input  logic                u_i,
  output logic [PM_W:0]       cand_c_o,
  output logic [TB_DEPTH-1:0] surv_c_o
);

  localparam int unsigned CW = PM_W + 1;

  logic [CW-1:0]       c0;
  logic [CW-1:0]       c1;
  logic                sel1;
  logic [TB_DEPTH-1:0] surv_sel;

  assign c0       = CW'(pm0_i) + CW'(bm0_i);
  assign c1       = CW'(pm1_i) + CW'(bm1_i);
  assign sel1     = (c1 < c0);
  assign cand_c_o = sel1 ? c1 : c0;
  assign surv_sel = sel1 ? surv1_i : surv0_i;
  // Register exchange: oldest decision falls off the top, newest bit enters at 0.
  assign surv_c_o = (surv_sel << 1) | TB_DEPTH'(u_i);

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision 4-state Viterbi decoder with min-normalised metrics and
// register-exchange survivors; decode latency is TB_DEPTH accepted symbols.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 5,
  parameter int unsigned PM_INIT  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [1:0]      conv_in,
  output logic            bit_out,
  output logic            out_valid,
  output logic [PM_W-1:0] best_metric
);

  localparam int unsigned CW    = PM_W + 1;
  localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_MAX = '1;

  logic [PM_W-1:0]     pm_q     [NUM_STATES];
  logic [PM_W-1:0]     pm_d     [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_q   [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_d   [NUM_STATES];
  logic [CW-1:0]       cand     [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_new [NUM_STATES];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             out_valid_q, out_valid_d;
  logic [PM_W-1:0]  best_metric_q, best_metric_d;

  logic [CW-1:0] min_cand;
  logic [1:0]    best;

  // Next state {u, a} is reached from {a, 0} and {a, 1}.
  for (genvar ns = 0; ns < int'(NUM_STATES); ns++) begin : g_acs
    localparam logic [1:0] P0 = 2'(2 * (ns % 2));
    localparam logic [1:0] P1 = P0 | 2'b01;
    localparam logic       U  = 1'(ns / 2);

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = hamming2(conv_in, expected_sym(P0, U));
    assign bm1 = hamming2(conv_in, expected_sym(P1, U));

    viterbi_acs #(
      .PM_W     (PM_W),
      .TB_DEPTH (TB_DEPTH)
    ) u_acs (
      .pm0_i    (pm_q[P0]),
      .pm1_i    (pm_q[P1]),
      .bm0_i    (bm0),
      .bm1_i    (bm1),
      .surv0_i  (surv_q[P0]),
      .surv1_i  (surv_q[P1]),
      .u_i      (U),
      .cand_c_o (cand[ns]),
      .surv_c_o (surv_new[ns])
    );
  end

  // Minimum candidate and the lowest-index state holding it.
  always_comb begin
    min_cand = cand[0];
    best     = 2'd0;
    for (int s = 1; s < int'(NUM_STATES); s++) begin
      if (cand[s] < min_cand) begin
        min_cand = cand[s];
        best     = 2'(s);
      end
    end
  end

  always_comb begin
    for (int s = 0; s < int'(NUM_STATES); s++) begin
      pm_d[s]   = pm_q[s];
      surv_d[s] = surv_q[s];
    end
    cnt_d         = cnt_q;
    bit_out_d     = bit_out_q;
    out_valid_d   = 1'b0;
    best_metric_d = best_metric_q;

    if (in_valid) begin
      for (int s = 0; s < int'(NUM_STATES); s++) begin
        pm_d[s]   = PM_W'(cand[s] - min_cand);
        surv_d[s] = surv_new[s];
      end
      // Stored metrics are normalised, so the previous minimum is always zero.
      best_metric_d = (min_cand > CW'(PM_MAX)) ? PM_MAX : PM_W'(min_cand);
      if (cnt_q >= CNT_W'(TB_DEPTH - 1)) begin
        out_valid_d = 1'b1;
        bit_out_d   = surv_new[best][TB_DEPTH-1];
      end
      if (cnt_q != CNT_W'(TB_DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(NUM_STATES); s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_W'(PM_INIT);
        surv_q[s] <= '0;
      end
      cnt_q         <= '0;
      bit_out_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      best_metric_q <= '0;
    end else begin
      for (int s = 0; s < int'(NUM_STATES); s++) begin
        pm_q[s]   <= pm_d[s];
        surv_q[s] <= surv_d[s];
      end
      cnt_q         <= cnt_d;
      bit_out_q     <= bit_out_d;
      out_valid_q   <= out_valid_d;
      best_metric_q <= best_metric_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign out_valid   = out_valid_q;
  assign best_metric = best_metric_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Randomised self-checking bench for viterbi_decoder against a full-path Viterbi model.
module tb_viterbi_decoder;
  import viterbi_pkg::*;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 5;
  localparam int PM_INIT  = 4;
  localparam int MAXLEN   = 256;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [1:0]      conv_in;
  logic            bit_out;
  logic            out_valid;
  logic [PM_W-1:0] best_metric;

  int n_checks;
  int n_errors;

  // Model state: absolute-style metrics and the complete decision history per state.
  int              m_pm   [4];
  logic [MAXLEN-1:0] m_path [4];
  int              m_len;
  logic            m_bit;
  int              m_bm;

  logic       tx_bits  [MAXLEN];
  logic [1:0] err_flip [MAXLEN];

  viterbi_decoder #(
    .TB_DEPTH (TB_DEPTH),
    .PM_W     (PM_W),
    .PM_INIT  (PM_INIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .conv_in     (conv_in),
    .bit_out     (bit_out),
    .out_valid   (out_valid),
    .best_metric (best_metric)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Code from the trellis definition: state {a,b}, input u -> {u^a^b, u^b}.
  function automatic logic [1:0] enc(input int s, input int u);
    int a, b;
    a = (s >> 1) & 1;
    b = s & 1;
    return {1'(u ^ a ^ b), 1'(u ^ b)};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_pm[s]   = (s == 0) ? 0 : PM_INIT;
      m_path[s] = '0;
    end
    m_len = 0;
    m_bit = 1'b0;
    m_bm  = 0;
  endtask

  task automatic model_step(input logic [1:0] sym, output logic ev);
    int cs [4];
    logic [MAXLEN-1:0] np [4];
    int old_min, mn, best;
    old_min = m_pm[0];
    for (int s = 1; s < 4; s++) if (m_pm[s] < old_min) old_min = m_pm[s];
    for (int ns = 0; ns < 4; ns++) begin
      int u, a, cbest, psel;
      u = ns / 2;
      a = ns % 2;
      cbest = 1000;
      psel  = 0;
      for (int q = 0; q < 2; q++) begin
        int p, c;
        p = 2 * a + q;
        c = m_pm[p] + $countones(sym ^ enc(p, u));
        if (c < cbest) begin
          cbest = c;
          psel  = p;
        end
      end
      cs[ns] = cbest;
      np[ns] = m_path[psel];
      np[ns][m_len] = 1'(u);
    end
    mn = cs[0];
    best = 0;
    for (int s = 1; s < 4; s++) if (cs[s] < mn) begin mn = cs[s]; best = s; end
    for (int s = 0; s < 4; s++) begin
      m_pm[s]   = cs[s] - mn;
      m_path[s] = np[s];
    end
    m_bm = mn - old_min;
    ev = (m_len >= TB_DEPTH - 1);
    if (ev) m_bit = np[best][m_len - TB_DEPTH + 1];
    m_len++;
  endtask

  task automatic step(input logic v, input logic [1:0] sym, output logic ev);
    in_valid = v;
    conv_in  = sym;
    @(posedge clk);
    ev = 1'b0;
    if (v) model_step(sym, ev);
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(ev));
    check_eq("bit_out", 32'(bit_out), 32'(m_bit));
    check_eq("best_metric", 32'(best_metric), 32'(m_bm));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_errs();
    for (int i = 0; i < MAXLEN; i++) err_flip[i] = 2'b00;
  endtask

  // mode 0: M-sequence, 1: all zero, 2: random bits. Last two bits are tail zeros.
  task automatic run_stream(input int n, input int gap, input int mode, input int rst_at,
                            output int bm_sum, output int n_out, output int first_out);
    int st;
    logic ev;
    logic [1:0] sym;
    bm_sum = 0;
    n_out = 0;
    first_out = -1;
    for (int i = 0; i < n; i++) begin
      if (mode == 1 || i >= n - 2) tx_bits[i] = 1'b0;
      else if (mode == 2) tx_bits[i] = 1'($urandom_range(1, 0));
      else if (i < 4) tx_bits[i] = (i != 1);
      else tx_bits[i] = tx_bits[i-1] ^ tx_bits[i-4];
    end
    st = 0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        #2 reset = 1'b1;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_bit_out", 32'(bit_out), 32'd0);
        check_eq("rst_best_metric", 32'(best_metric), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        return;
      end
      for (int g = 1; g < gap; g++) step(1'b0, 2'($urandom_range(3, 0)), ev);
      sym = enc(st, int'(tx_bits[i])) ^ err_flip[i];
      st = (int'(tx_bits[i]) << 1) | ((st >> 1) & 1);
      step(1'b1, sym, ev);
      bm_sum += int'(best_metric);
      if (ev) begin
        check_eq("decoded_vs_tx", 32'(bit_out), 32'(tx_bits[n_out]));
        if (n_out == 0) first_out = i;
        n_out++;
      end
    end
  endtask

  initial begin
    int bm_sum, n_out, first_out;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    conv_in = 2'b00;
    model_reset();
    clear_errs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_bit_out", 32'(bit_out), 32'd0);
    check_eq("reset_best_metric", 32'(best_metric), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 2; u++)
        check_eq("pkg_expected_sym", 32'(expected_sym(2'(s), 1'(u))), 32'(enc(s, u)));

    // Error-free M-sequence, back to back.
    run_stream(64, 1, 0, -1, bm_sum, n_out, first_out);
    check_eq("clean_first_out", 32'(first_out), 32'(TB_DEPTH - 1));
    check_eq("clean_n_out", 32'(n_out), 32'(64 - TB_DEPTH + 1));
    check_eq("clean_bm_sum", 32'(bm_sum), 32'd0);

    // Single error on the g7 bit of symbol 20.
    do_reset();
    clear_errs();
    err_flip[20] = 2'b10;
    run_stream(64, 1, 0, -1, bm_sum, n_out, first_out);
    check_eq("err1_bm_sum", 32'(bm_sum), 32'd1);

    // All-zero input.
    do_reset();
    clear_errs();
    run_stream(40, 1, 1, -1, bm_sum, n_out, first_out);
    check_eq("zero_n_out", 32'(n_out), 32'd25);
    check_eq("zero_bm_sum", 32'(bm_sum), 32'd0);

    // Strobe every third cycle.
    do_reset();
    run_stream(64, 3, 0, -1, bm_sum, n_out, first_out);
    check_eq("gap_n_out", 32'(n_out), 32'(64 - TB_DEPTH + 1));
    check_eq("gap_bm_sum", 32'(bm_sum), 32'd0);

    // Two spaced errors.
    do_reset();
    err_flip[10] = 2'b01;
    err_flip[25] = 2'b10;
    run_stream(64, 1, 0, -1, bm_sum, n_out, first_out);
    check_eq("err2_bm_sum", 32'(bm_sum), 32'd2);

    // Asynchronous reset mid-stream, then a fresh stream.
    do_reset();
    clear_errs();
    run_stream(64, 1, 0, 30, bm_sum, n_out, first_out);
    run_stream(48, 1, 2, -1, bm_sum, n_out, first_out);
    check_eq("post_rst_first_out", 32'(first_out), 32'(TB_DEPTH - 1));
    check_eq("post_rst_n_out", 32'(n_out), 32'(48 - TB_DEPTH + 1));

    // Random streams with random gaps and well-separated single-bit errors.
    for (int r = 0; r < 4; r++) begin
      int pos;
      do_reset();
      clear_errs();
      pos = 6 + int'($urandom_range(3, 0));
      while (pos < 60 - 20) begin
        err_flip[pos] = ($urandom_range(1, 0) != 0) ? 2'b10 : 2'b01;
        pos += 14 + int'($urandom_range(5, 0));
      end
      run_stream(60, int'($urandom_range(3, 1)), 2, -1, bm_sum, n_out, first_out);
      check_eq("rand_n_out", 32'(n_out), 32'(60 - TB_DEPTH + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
